// File: rtl/uart_stim_tx.sv
// UART transmit stimulus source: a byte FIFO feeding a frame serialiser with
// configurable payload width, parity, stop bits and baud divisor.
module uart_stim_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int BAUD_DIV   = CLK_HZ / BAUD_RATE,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_valid_i,
  input  logic [DATA_BITS-1:0]          wr_data_i,
  output logic                          wr_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_FW   = PTR_W + 1;
  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int CNT_W    = $clog2(STOP_LEN + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [CNT_W-1:0]  STOP_PRE  = CNT_W'(STOP_LEN - 2);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [CNT_FW-1:0] FULL_CNT  = CNT_FW'(FIFO_DEPTH);
  localparam logic              PAR_ODD   = (PARITY == 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_stim_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_stim_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_stim_tx: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_stim_tx: BAUD_DIV must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_stim_tx: FIFO_DEPTH must be a power of 2, at least 2");
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_FW-1:0]    fifo_cnt_q;
  logic                 push;
  logic                 pop;

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot for a push.
  assign wr_ready_o   = (fifo_cnt_q < FULL_CNT);
  assign push         = wr_valid_i && wr_ready_o;
  assign fifo_count_o = fifo_cnt_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------- serialiser
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 bit_end;
  logic                 stop_end;

  assign bit_end  = (cnt_q == BIT_LAST);
  assign stop_end = (cnt_q == STOP_LAST);
  assign pop      = (fifo_cnt_q != '0) &&
                    ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_end));

  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_START;
            cnt_q   <= '0;
            data_q  <= fifo_mem[rd_ptr_q];
            par_q   <= PAR_ODD;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= data_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          // data_q[0] is always the bit on the line; parity accumulates as
          // each bit finishes, so it is ready when the last bit ends.
          if (bit_end) begin
            cnt_q <= '0;
            par_q <= par_q ^ data_q[0];
            if (bit_q == DATA_LAST) begin
              if (PARITY != 0) begin
                state_q <= S_PAR;
                tx_q    <= par_q ^ data_q[0];
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q  <= bit_q + 1'b1;
              data_q <= data_q >> 1;
              tx_q   <= data_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state_q <= S_STOP;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (stop_end) begin
            cnt_q <= '0;
            if (pop) begin
              state_q <= S_START;
              data_q  <= fifo_mem[rd_ptr_q];
              par_q   <= PAR_ODD;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == STOP_PRE) begin
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx: five configurations driven side by side and checked
// every cycle against a frame-position model, plus literal waveform checks.
module tb_uart_stim_tx;

  localparam int NI  = 5;
  localparam int DIV = 10;
  // u0 8N1/16, u1 8N2/4, u2 8E1/16, u3 8O1/16, u4 7N2/2
  localparam int DB  [NI] = '{8, 8, 8, 8, 7};
  localparam int PAR [NI] = '{0, 0, 2, 1, 0};
  localparam int SB  [NI] = '{1, 2, 1, 1, 2};
  localparam int DEP [NI] = '{16, 4, 16, 16, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [NI];
  logic       wv   [NI];
  logic [7:0] wd   [NI];
  logic       tx   [NI];
  logic       busy [NI];
  logic       done [NI];
  logic       rdy  [NI];
  logic [4:0] fc0, fc2, fc3;
  logic [2:0] fc1;
  logic [1:0] fc4;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt [NI];

  uart_stim_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .wr_valid_i(wv[0]), .wr_data_i(wd[0]),
    .wr_ready_o(rdy[0]), .tx_o(tx[0]), .busy_o(busy[0]),
    .frame_done_o(done[0]), .fifo_count_o(fc0));
  uart_stim_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .wr_valid_i(wv[1]), .wr_data_i(wd[1]),
    .wr_ready_o(rdy[1]), .tx_o(tx[1]), .busy_o(busy[1]),
    .frame_done_o(done[1]), .fifo_count_o(fc1));
  uart_stim_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .wr_valid_i(wv[2]), .wr_data_i(wd[2]),
    .wr_ready_o(rdy[2]), .tx_o(tx[2]), .busy_o(busy[2]),
    .frame_done_o(done[2]), .fifo_count_o(fc2));
  uart_stim_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u3 (
    .clk_i(clk), .rst_i(rst[3]), .wr_valid_i(wv[3]), .wr_data_i(wd[3]),
    .wr_ready_o(rdy[3]), .tx_o(tx[3]), .busy_o(busy[3]),
    .frame_done_o(done[3]), .fifo_count_o(fc3));
  uart_stim_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(2)) u4 (
    .clk_i(clk), .rst_i(rst[4]), .wr_valid_i(wv[4]), .wr_data_i(wd[4][6:0]),
    .wr_ready_o(rdy[4]), .tx_o(tx[4]), .busy_o(busy[4]),
    .frame_done_o(done[4]), .fifo_count_o(fc4));

  // ------------------------------------------------------------ model
  // Each instance is a queue of accepted bytes plus, while busy, the frame
  // being sent and the cycle offset into it.
  logic [7:0] m_buf [NI][16];
  int         m_head [NI];
  int         m_size [NI];
  int         m_t    [NI];
  bit         m_busy [NI];
  logic [7:0] m_frame [NI];
  int         sz0;

  function automatic int flen(input int i);
    return (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i]) * DIV;
  endfunction

  function automatic logic [7:0] mask(input int i);
    return 8'((1 << DB[i]) - 1);
  endfunction

  function automatic void model_pop(input int i);
    m_frame[i] = m_buf[i][m_head[i]];
    m_head[i]  = (m_head[i] + 1) % 16;
    m_size[i]  = m_size[i] - 1;
    m_busy[i]  = 1'b1;
    m_t[i]     = 0;
  endfunction

  function automatic logic exp_tx(input int i);
    int k;
    if (!m_busy[i]) return 1'b1;
    k = m_t[i] / DIV;
    if (k == 0) return 1'b0;
    if (k <= DB[i]) return m_frame[i][k-1];
    if (PAR[i] != 0 && k == DB[i] + 1)
      return (($countones(m_frame[i]) % 2) == 1) ^ (PAR[i] == 1);
    return 1'b1;
  endfunction

  function automatic logic exp_done(input int i);
    return m_busy[i] && (m_t[i] == flen(i) - 1);
  endfunction

  function automatic logic [31:0] get_fc(input int i);
    case (i)
      0:       return 32'(fc0);
      1:       return 32'(fc1);
      2:       return 32'(fc2);
      3:       return 32'(fc3);
      default: return 32'(fc4);
    endcase
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        m_head[i] = 0;
        m_size[i] = 0;
        m_busy[i] = 1'b0;
        m_t[i]    = 0;
      end else begin
        sz0 = m_size[i];
        if (m_busy[i]) begin
          m_t[i] = m_t[i] + 1;
          if (m_t[i] == flen(i)) begin
            if (sz0 > 0) model_pop(i);
            else         m_busy[i] = 1'b0;
          end
        end else if (sz0 > 0) begin
          model_pop(i);
        end
        if (wv[i] && sz0 < DEP[i]) begin
          m_buf[i][(m_head[i] + m_size[i]) % 16] = wd[i] & mask(i);
          m_size[i] = m_size[i] + 1;
        end
      end
    end
  end

  // ------------------------------------------------------------ checking
  task automatic chk(input string nm, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u%0d cyc %0d got %0h exp %0h", nm, inst, cyc, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input int inst, input logic got, input logic exp);
    chk(nm, inst, 32'(got), 32'(exp));
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < NI; i++) begin
        chk1("tx", i, tx[i], exp_tx(i));
        chk1("busy", i, busy[i], m_busy[i]);
        chk1("frame_done", i, done[i], exp_done(i));
        chk("fifo_count", i, get_fc(i), 32'(m_size[i]));
        chk1("wr_ready", i, rdy[i], m_size[i] < DEP[i]);
        if (done[i] === 1'b1) done_cnt[i]++;
      end
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // ------------------------------------------------------------ stimulus
  logic [7:0] pat55;

  initial begin
    pat55 = 8'h55;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; wv[i] = 1'b0; wd[i] = 8'h00; done_cnt[i] = 0;
      m_head[i] = 0; m_size[i] = 0; m_t[i] = 0; m_busy[i] = 1'b0;
    end
    at_cyc(2);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;

    at_cyc(3);
    for (int i = 0; i < NI; i++) begin
      chk1("rst_tx", i, tx[i], 1'b1);
      chk1("rst_busy", i, busy[i], 1'b0);
      chk1("rst_done", i, done[i], 1'b0);
      chk1("rst_ready", i, rdy[i], 1'b1);
      chk("rst_count", i, get_fc(i), 32'd0);
    end

    // One frame per instance pushed at edge 5; u1 gets a second byte at edge 6.
    at_cyc(4);
    wd[0] = 8'h55; wd[1] = 8'h00; wd[2] = 8'hA5; wd[3] = 8'hA5; wd[4] = 8'h7F;
    for (int i = 0; i < NI; i++) wv[i] = 1'b1;
    at_cyc(5);
    wv[0] = 1'b0; wv[2] = 1'b0; wv[3] = 1'b0; wv[4] = 1'b0; wd[1] = 8'hFF;
    chk("lit_cnt7_one", 4, get_fc(4), 32'd1);
    at_cyc(6);
    wv[1] = 1'b0;
    chk1("lit_start_lo", 0, tx[0], 1'b0);
    chk1("lit_start_lo", 4, tx[4], 1'b0);
    chk("lit_cnt7_zero", 4, get_fc(4), 32'd0);
    at_cyc(15);
    chk1("lit_start_end", 0, tx[0], 1'b0);
    for (int b = 0; b < 8; b++) begin
      at_cyc(16 + 10 * b);
      chk1("lit_data55", 0, tx[0], pat55[b]);
    end
    at_cyc(96);
    chk1("lit_stop_hi", 0, tx[0], 1'b1);
    at_cyc(100);
    chk1("lit_even_par", 2, tx[2], 1'b0);
    chk1("lit_odd_par", 3, tx[3], 1'b1);
    at_cyc(104);
    chk1("lit_done_early", 0, done[0], 1'b0);
    at_cyc(105);
    chk1("lit_done", 0, done[0], 1'b1);
    chk1("lit_done7", 4, done[4], 1'b1);
    at_cyc(106);
    chk1("lit_idle_busy", 0, busy[0], 1'b0);
    chk1("lit_idle_busy7", 4, busy[4], 1'b0);
    chk("lit_done_cnt", 0, 32'(done_cnt[0]), 32'd1);
    at_cyc(115);
    chk1("lit_done_b2b1", 1, done[1], 1'b1);
    chk1("lit_done_par", 2, done[2], 1'b1);
    at_cyc(116);
    chk1("lit_b2b_start", 1, tx[1], 1'b0);
    chk1("lit_b2b_busy", 1, busy[1], 1'b1);
    at_cyc(225);
    chk1("lit_done_b2b2", 1, done[1], 1'b1);
    at_cyc(226);
    chk1("lit_b2b_idle", 1, busy[1], 1'b0);

    // Depth-4 overflow on u1 with the line already busy.
    at_cyc(297);
    wv[1] = 1'b1; wd[1] = 8'hC3;
    at_cyc(298);
    wv[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      at_cyc(299 + k);
      if (k == 3) chk("lit_fill3", 1, get_fc(1), 32'd3);
      if (k == 4) begin
        chk("lit_full", 1, get_fc(1), 32'd4);
        chk1("lit_full_rdy", 1, rdy[1], 1'b0);
      end
      wv[1] = 1'b1; wd[1] = 8'(8'h10 + k);
    end
    at_cyc(305);
    wv[1] = 1'b0;
    chk("lit_dropped", 1, get_fc(1), 32'd4);
    at_cyc(900);
    chk("lit_frames_u1", 1, 32'(done_cnt[1]), 32'd7);

    // Reset in the middle of the data bits of 0x3C with two bytes queued.
    at_cyc(999);
    wv[0] = 1'b1; wd[0] = 8'h3C;
    at_cyc(1000);
    wd[0] = 8'h11;
    at_cyc(1001);
    wd[0] = 8'h22;
    at_cyc(1002);
    wv[0] = 1'b0;
    at_cyc(1039);
    chk("lit_pre_rst_cnt", 0, get_fc(0), 32'd2);
    rst[0] = 1'b1;
    at_cyc(1040);
    rst[0] = 1'b0;
    chk1("lit_rst_tx", 0, tx[0], 1'b1);
    chk1("lit_rst_busy", 0, busy[0], 1'b0);
    chk("lit_rst_cnt", 0, get_fc(0), 32'd0);
    at_cyc(1300);
    chk("lit_no_frames", 0, 32'(done_cnt[0]), 32'd1);
    chk1("lit_still_idle", 0, busy[0], 1'b0);

    // Randomised traffic with occasional resets, then drain.
    repeat (20000) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        rst[i] = ($urandom_range(0, 3999) == 0);
        wv[i]  = ($urandom_range(0, 39) == 0);
        wd[i]  = 8'($urandom);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0; wv[i] = 1'b0;
    end
    repeat (2500) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk1("drained_busy", i, busy[i], 1'b0);
      chk("drained_cnt", i, get_fc(i), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
